// File: rtl/wr_mux_2to1.sv
// wr_mux_2to1: joins two AXI write masters onto one slave port.
// The AW channel is arbitrated round-robin. The grant is then held through
// the burst's WLAST beat, so W beats of one burst are never interleaved with
// another master's. ID bit 1 is replaced by the master index. This lets the
// downstream B demux route responses back on bid[1].
module wr_mux_2to1 (
  input  logic        aclk,
  input  logic        areset,

  input  logic [3:0]  awid_m1,
  input  logic [31:0] awaddr_m1,
  input  logic [3:0]  awlen_m1,
  input  logic [2:0]  awsize_m1,
  input  logic [1:0]  awburst_m1,
  input  logic        awvalid_m1,
  output logic        awready_m1,
  input  logic [3:0]  wid_m1,
  input  logic [31:0] wdata_m1,
  input  logic [3:0]  wstrb_m1,
  input  logic        wlast_m1,
  input  logic        wvalid_m1,
  output logic        wready_m1,

  input  logic [3:0]  awid_m2,
  input  logic [31:0] awaddr_m2,
  input  logic [3:0]  awlen_m2,
  input  logic [2:0]  awsize_m2,
  input  logic [1:0]  awburst_m2,
  input  logic        awvalid_m2,
  output logic        awready_m2,
  input  logic [3:0]  wid_m2,
  input  logic [31:0] wdata_m2,
  input  logic [3:0]  wstrb_m2,
  input  logic        wlast_m2,
  input  logic        wvalid_m2,
  output logic        wready_m2,

  output logic [3:0]  awid_s,
  output logic [31:0] awaddr_s,
  output logic [3:0]  awlen_s,
  output logic [2:0]  awsize_s,
  output logic [1:0]  awburst_s,
  output logic        awvalid_s,
  input  logic        awready_s,
  output logic [3:0]  wid_s,
  output logic [31:0] wdata_s,
  output logic [3:0]  wstrb_s,
  output logic        wlast_s,
  output logic        wvalid_s,
  input  logic        wready_s
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t state;
  logic   grant;       // 0 selects m1, 1 selects m2
  logic   last_grant;  // master that completed the most recent burst

  logic [3:0] awid_g;
  logic [3:0] wid_g;
  logic       awvalid_g;
  logic       wvalid_g;
  logic       in_addr;
  logic       in_data;

  assign in_addr = (state == ADDR);
  assign in_data = (state == DATA);

  // Arbitration and burst-phase sequencing.
  // Ties go to the master that did not finish the previous burst.
  // last_grant resets to m2 so that m1 wins the first tie.
  always_ff @(posedge aclk or negedge areset) begin
    if (!areset) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (awvalid_m1 && awvalid_m2) begin
            grant <= ~last_grant;
            state <= ADDR;
          end else if (awvalid_m1) begin
            grant <= 1'b0;
            state <= ADDR;
          end else if (awvalid_m2) begin
            grant <= 1'b1;
            state <= ADDR;
          end
        end
        ADDR: begin
          if (awvalid_s && awready_s) begin
            state <= DATA;
          end
        end
        DATA: begin
          if (wvalid_s && wready_s && wlast_s) begin
            state      <= IDLE;
            last_grant <= grant;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Granted master's fields. Payload always follows the grant. It is only
  // meaningful while the matching valid is high.
  assign awid_g    = grant ? awid_m2    : awid_m1;
  assign awvalid_g = grant ? awvalid_m2 : awvalid_m1;
  assign wid_g     = grant ? wid_m2     : wid_m1;
  assign wvalid_g  = grant ? wvalid_m2  : wvalid_m1;

  assign awid_s    = {awid_g[3:2], grant, awid_g[0]};
  assign awaddr_s  = grant ? awaddr_m2  : awaddr_m1;
  assign awlen_s   = grant ? awlen_m2   : awlen_m1;
  assign awsize_s  = grant ? awsize_m2  : awsize_m1;
  assign awburst_s = grant ? awburst_m2 : awburst_m1;
  assign awvalid_s = in_addr & awvalid_g;

  assign wid_s     = {wid_g[3:2], grant, wid_g[0]};
  assign wdata_s   = grant ? wdata_m2   : wdata_m1;
  assign wstrb_s   = grant ? wstrb_m2   : wstrb_m1;
  assign wlast_s   = grant ? wlast_m2   : wlast_m1;
  assign wvalid_s  = in_data & wvalid_g;

  // Readies reach only the granted master, and only in its own phase. This
  // holds off W issued early until the address has been accepted.
  assign awready_m1 = in_addr & ~grant & awready_s;
  assign awready_m2 = in_addr &  grant & awready_s;
  assign wready_m1  = in_data & ~grant & wready_s;
  assign wready_m2  = in_data &  grant & wready_s;

endmodule
